// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state/mode types and default widths for the I2S receiver.
package i2s_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PAD} i2s_state_t;
    typedef enum logic {I2S_STD, I2S_LJ} i2s_mode_t;
    localparam int I2S_DATA_W = 24;
    localparam int I2S_SLOT_W = 32;
endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: multi-flop synchroniser with a registered level and rise strobe.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);
    logic [STAGES-1:0] sync;

    // level is delayed one extra flop so it stays aligned with the registered rise strobe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], d};
            level <= sync[STAGES-1];
            rise  <= sync[STAGES-1] & ~level;
        end
endmodule

// File: rtl/i2s_stereo_receiver.sv
// i2s_stereo_receiver: oversampling I2S / left-justified stereo deserialiser
// with paired-sample valid pulse and short/long slot error detection.
module i2s_stereo_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W,
    parameter int SLOT_W      = I2S_SLOT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              sdin,
    input  logic              mode_lj,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              dvalid,
    output logic              frame_err
);
    localparam int CW = $clog2(SLOT_W + 2);

    logic              bit_ev, lr, sd, lr_prev, chan, left_ok;
    logic [2:0]        unused_sig;
    logic              lr_edge, start_lj, last, done, start;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg, sh_nxt;
    logic [DATA_W:0]   cat;
    i2s_mode_t         mode_q;
    i2s_state_t        state;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(mclk), .rst(rst), .d(sclk), .level(unused_sig[0]), .rise(bit_ev));
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrclk (
        .clk(mclk), .rst(rst), .d(lrclk), .level(lr), .rise(unused_sig[1]));
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sdin (
        .clk(mclk), .rst(rst), .d(sdin), .level(sd), .rise(unused_sig[2]));

    assign cat      = {shreg, sd};
    assign sh_nxt   = cat[DATA_W-1:0];
    assign lr_edge  = lr ^ lr_prev;
    assign start_lj = lr ? (mode_q == I2S_LJ) : mode_lj;
    assign last     = cnt == CW'(DATA_W - 1);
    // in I2S the previous word's LSB rides on the next slot's edge event
    assign done     = bit_ev && state == SHIFT && last && !(lr_edge && mode_q == I2S_LJ);
    assign start    = bit_ev && lr_edge && (state != IDLE || !lr);

    always_ff @(posedge mclk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            left_data  <= '0;
            right_data <= '0;
            dvalid     <= 1'b0;
            frame_err  <= 1'b0;
            left_ok    <= 1'b0;
            lr_prev    <= 1'b0;
            chan       <= 1'b0;
            mode_q     <= I2S_STD;
            cnt        <= '0;
            shreg      <= '0;
        end else begin
            dvalid    <= 1'b0;
            frame_err <= 1'b0;
            if (bit_ev)
                lr_prev <= lr;
            if (done) begin
                if (chan) begin
                    right_data <= sh_nxt;
                    dvalid     <= left_ok;
                end else begin
                    left_data <= sh_nxt;
                    left_ok   <= 1'b1;
                end
            end
            if (start) begin
                frame_err <= state == SHIFT && !done;
                state     <= SHIFT;
                chan      <= lr;
                cnt       <= start_lj ? CW'(1) : '0;
                shreg     <= sh_nxt;
                if (!lr) begin
                    mode_q  <= i2s_mode_t'(mode_lj);
                    left_ok <= 1'b0;
                end
            end else if (bit_ev && state == SHIFT) begin
                shreg <= sh_nxt;
                cnt   <= cnt + CW'(1);
                if (last)
                    state <= PAD;
            end else if (bit_ev && state == PAD) begin
                if (cnt == CW'(SLOT_W + 1)) begin
                    frame_err <= 1'b1;
                    left_ok   <= 1'b0;
                    state     <= IDLE;
                end else if (cnt != '1)
                    cnt <= cnt + CW'(1);
            end
        end
endmodule

// File: tb/tb_i2s_stereo_receiver.sv
// tb_i2s_stereo_receiver: randomized frames against a word-level expectation model,
// run on a 24/32 and a 16/32 receiver sharing the same serial stream.
module tb_i2s_stereo_receiver;
    localparam int S = 2;

    logic mclk = 0, rst = 1, sclk = 0, lrclk = 1, sdin = 0, mode_lj = 0;
    logic [23:0] l24, r24;
    logic [15:0] l16, r16;
    logic dv24, fe24, dv16, fe16;
    int checks = 0, errors = 0, cyc = 0, rise_cyc = 0;
    int fe24_n = 0, fe16_n = 0, b24 = 0, b16 = 0;
    bit dly = 1, prev_b = 0;
    logic [47:0] q24[$];
    logic [31:0] q16[$];
    logic [47:0] e24;
    logic [31:0] e16;
    logic [23:0] cl24 = 0, cr24 = 0;
    logic [15:0] cl16 = 0, cr16 = 0;
    logic [31:0] w;

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    i2s_stereo_receiver #(.DATA_W(24), .SLOT_W(32), .SYNC_STAGES(S)) dut (
        .mclk(mclk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdin(sdin), .mode_lj(mode_lj),
        .left_data(l24), .right_data(r24), .dvalid(dv24), .frame_err(fe24));
    i2s_stereo_receiver #(.DATA_W(16), .SLOT_W(32), .SYNC_STAGES(S)) dut16 (
        .mclk(mclk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdin(sdin), .mode_lj(mode_lj),
        .left_data(l16), .right_data(r16), .dvalid(dv16), .frame_err(fe16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge mclk)
        if (!rst) begin
            if (fe24) fe24_n++;
            if (fe16) fe16_n++;
            if (dv24) begin
                if (q24.size() == 0) check("dv24_unexpected", 1, 0);
                else begin
                    e24 = q24.pop_front();
                    check("left24", 32'(l24), 32'(e24[47:24]));
                    check("right24", 32'(r24), 32'(e24[23:0]));
                end
                check("latency", cyc - rise_cyc, S + 2);
            end
            if (dv16) begin
                if (q16.size() == 0) check("dv16_unexpected", 1, 0);
                else begin
                    e16 = q16.pop_front();
                    check("left16", 32'(l16), 32'(e16[31:16]));
                    check("right16", 32'(r16), 32'(e16[15:0]));
                end
            end
        end

    // one sclk period: data/lrclk change on the falling edge; I2S delays data by one bit
    task automatic put(input bit lr, input bit b);
        sclk = 0;
        lrclk = lr;
        sdin = dly ? prev_b : b;
        prev_b = b;
        repeat (4) @(negedge mclk);
        sclk = 1;
        rise_cyc = cyc;
        repeat (4) @(negedge mclk);
    endtask

    task automatic slot(input bit lr, input logic [31:0] sw, input int n);
        for (int k = 0; k < n; k++) put(lr, k < 32 ? sw[31-k] : 1'b0);
    endtask

    task automatic frame(input logic [31:0] lw, input logic [31:0] rw, input bit sh, input bit dv);
        logic [31:0] lx, rx;
        lx = sh ? lw << 1 : lw;
        rx = sh ? rw << 1 : rw;
        cl24 = lx[31:8];
        cr24 = rx[31:8];
        cl16 = lx[31:16];
        cr16 = rx[31:16];
        if (dv) begin
            q24.push_back({lx[31:8], rx[31:8]});
            q16.push_back({lx[31:16], rx[31:16]});
        end
        slot(0, lw, 32);
        slot(1, rw, 32);
    endtask

    task automatic scen_end(input string tag, input int nerr);
        check({tag, "_pending24"}, q24.size(), 0);
        check({tag, "_pending16"}, q16.size(), 0);
        check({tag, "_ferr24"}, fe24_n - b24, nerr);
        check({tag, "_ferr16"}, fe16_n - b16, nerr);
        b24 = fe24_n;
        b16 = fe16_n;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_l24"}, 32'(l24), 32'(cl24));
        check({tag, "_r24"}, 32'(r24), 32'(cr24));
        check({tag, "_l16"}, 32'(l16), 32'(cl16));
        check({tag, "_r16"}, 32'(r16), 32'(cr16));
    endtask

    initial begin
        repeat (5) @(negedge mclk);
        check_outs("reset");
        check("reset_dv", 32'({dv24, dv16, fe24, fe16}), 0);
        rst = 0;
        slot(1, 0, 3);
        frame({24'hA5A5A5, 8'($urandom)}, {24'h5A5A5A, 8'($urandom)}, 0, 1);
        frame(32'h1234FFFF, $urandom, 0, 1);
        for (int i = 0; i < 5; i++) frame($urandom, $urandom, 0, 1);
        scen_end("i2s", 0);

        mode_lj = 1;
        dly = 0;
        frame({24'h800001, 8'($urandom)}, {24'h7FFFFE, 8'($urandom)}, 0, 1);
        for (int i = 0; i < 4; i++) frame($urandom, $urandom, 0, 1);
        scen_end("lj", 0);

        mode_lj = 0;
        frame(32'h80000100, 32'h7FFFFE00, 1, 1);
        check("shift_l24", 32'(l24), 32'h000002);
        check("shift_r24", 32'(r24), 32'hFFFFFC);
        scen_end("shift", 0);

        dly = 1;
        slot(0, $urandom, 10);
        slot(1, 32'h00FF0000, 32);
        cr24 = 24'h00FF00;
        cr16 = 16'h00FF;
        check_outs("short");
        frame($urandom, $urandom, 0, 1);
        scen_end("short", 1);

        w = $urandom;
        slot(0, w, 40);
        cl24 = w[31:8];
        cl16 = w[31:16];
        slot(1, $urandom, 32);
        check_outs("long");
        frame($urandom, $urandom, 0, 1);
        scen_end("long", 1);

        slot(0, $urandom, 32);
        slot(1, $urandom, 12);
        rst = 1;
        repeat (3) @(negedge mclk);
        {cl24, cr24, cl16, cr16} = '0;
        check_outs("midrst");
        check("midrst_dv", 32'({dv24, dv16, fe24, fe16}), 0);
        rst = 0;
        slot(1, $urandom, 20);
        check_outs("postrst");
        frame($urandom, $urandom, 0, 1);
        scen_end("reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
